// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line levels and the
// default bit timing that both the transmitter and the receiver are built on.
package uart_pkg;

  // Transmit FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Line levels for the framing bits and the idle line.
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Default clocks per serial bit; the receiver samples with the same period.
  localparam int CLKS_PER_BIT = 10;

  // Width of a counter that must hold 0..clks-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int clks);
    int w;
    w = $clog2(clks);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear, enable and programmable
// rollover value. Wraps to zero after reaching rollover_val; rollover_flag
// marks the enabled cycle in which that wrap will happen.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_r;
  logic [NUM_CNT_BITS-1:0] count_next_s;
  logic                    at_max_s;

  assign at_max_s = (count_r == rollover_val);

  // Next count: clear wins, then enabled increment with wrap at rollover_val.
  always_comb begin
    count_next_s = count_r;
    if (clear) begin
      count_next_s = '0;
    end else if (count_enable) begin
      if (at_max_s) begin
        count_next_s = '0;
      end else begin
        count_next_s = count_r + NUM_CNT_BITS'(1);
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_r <= '0;
    end else begin
      count_r <= count_next_s;
    end
  end

  assign count_out     = count_r;
  assign rollover_flag = count_enable & ~clear & at_max_s;

endmodule

// File: rtl/tx_timer.sv
// Bit timing for the transmitter. A bit-period counter produces bit_strobe on
// the last clock of every serial bit; a bit counter, advanced only by strobes
// during the data phase, tracks which data bit is on the line.
module tx_timer #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  input  logic data_phase,
  output logic bit_strobe,
  output logic last_bit,
  output logic data_end
);

  import uart_pkg::*;

  localparam int              CW         = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0]   PERIOD_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_IDX   = 3'(DATA_BITS - 1);

  logic [CW-1:0] period_cnt_s;
  logic [2:0]    bit_idx_s;
  logic          bit_cnt_en_s;

  // Bit counter advances on the final clock of each data bit period.
  assign bit_cnt_en_s = enable & data_phase & (period_cnt_s == PERIOD_MAX);

  flex_counter #(
    .NUM_CNT_BITS(CW)
  ) u_period_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (enable),
    .rollover_val (PERIOD_MAX),
    .count_out    (period_cnt_s),
    .rollover_flag(bit_strobe)
  );

  // Wraps back to zero as the last data bit completes, ready for next frame.
  flex_counter #(
    .NUM_CNT_BITS(3)
  ) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (bit_cnt_en_s),
    .rollover_val (LAST_IDX),
    .count_out    (bit_idx_s),
    .rollover_flag(data_end)
  );

  assign last_bit = (bit_idx_s == LAST_IDX);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts one word through a ready/start handshake and
// sends it as a start bit, DATA_BITS data bits LSB first, and one stop bit.
// All outputs are registered; next-cycle values are computed from the next
// state so the start bit appears on the line right after the accept edge.
module uart_tx #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 ready,
  output logic                 tx_out,
  output logic                 tx_done
);

  import uart_pkg::*;

  tx_state_t            state_r;
  tx_state_t            state_next_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_next_s;
  logic                 tx_out_r;
  logic                 tx_out_next_s;
  logic                 ready_r;
  logic                 ready_next_s;
  logic                 done_r;
  logic                 done_next_s;
  logic                 accept_s;
  logic                 bit_strobe_s;
  logic                 last_bit_s;
  logic                 data_end_s;

  // A start request only counts while idle; requests while busy are dropped.
  assign accept_s = (state_r == IDLE) & tx_start;

  tx_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_BITS   (DATA_BITS)
  ) u_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (accept_s),
    .enable    (state_r != IDLE),
    .data_phase(state_r == DATA),
    .bit_strobe(bit_strobe_s),
    .last_bit  (last_bit_s),
    .data_end  (data_end_s)
  );

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: each phase lasts whole bit periods.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (tx_start) begin
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (bit_strobe_s) begin
          state_next_s = DATA;
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (data_end_s) begin
          state_next_s = STOP;
        end else begin
          state_next_s = DATA;
        end
      end
      STOP: begin
        if (bit_strobe_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = STOP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output logic: shift register update and next values of the output flops.
  always_comb begin
    shift_next_s = shift_r;
    if (accept_s) begin
      shift_next_s = tx_data;
    end else if ((state_r == DATA) && bit_strobe_s && !last_bit_s) begin
      shift_next_s = shift_r >> 1;
    end else begin
      shift_next_s = shift_r;
    end

    tx_out_next_s = IDLE_LEVEL;
    case (state_next_s)
      IDLE:    tx_out_next_s = IDLE_LEVEL;
      START:   tx_out_next_s = START_BIT;
      DATA:    tx_out_next_s = shift_next_s[0];
      STOP:    tx_out_next_s = STOP_BIT;
      default: tx_out_next_s = IDLE_LEVEL;
    endcase

    ready_next_s = (state_next_s == IDLE);
    done_next_s  = (state_r == STOP) && bit_strobe_s;
  end

  // Datapath and output registers; reset drives the line to its idle level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_r  <= '0;
      tx_out_r <= IDLE_LEVEL;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
    end else begin
      shift_r  <= shift_next_s;
      tx_out_r <= tx_out_next_s;
      ready_r  <= ready_next_s;
      done_r   <= done_next_s;
    end
  end

  assign tx_out  = tx_out_r;
  assign ready   = ready_r;
  assign tx_done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (10/8, 2/5, 16/7 clocks-per-bit/data
// bits) compared every cycle against a frame-position model, plus directed
// literal checks on decoded words, frame lengths and done timing.
module tb_uart_tx;

  localparam int NI = 3;
  localparam int CPB [NI] = '{10, 2, 16};
  localparam int DB  [NI] = '{8, 5, 7};

  logic          clk = 1'b0;
  logic          n_rst;
  logic [NI-1:0] tx_start_a;
  logic [NI-1:0] ready_a;
  logic [NI-1:0] tx_out_a;
  logic [NI-1:0] tx_done_a;
  logic [7:0]    tx_data_a [NI];

  int vectors = 0;
  int miscompares = 0;

  // Model: whether a frame is in flight, clocks since its accept edge, word.
  bit         mact  [NI];
  int         mt    [NI];
  logic [7:0] mdata [NI];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(10), .DATA_BITS(8)) u_dut0 (
    .clk(clk), .n_rst(n_rst), .tx_data(tx_data_a[0]), .tx_start(tx_start_a[0]),
    .ready(ready_a[0]), .tx_out(tx_out_a[0]), .tx_done(tx_done_a[0]));
  uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(5)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .tx_data(tx_data_a[1][4:0]), .tx_start(tx_start_a[1]),
    .ready(ready_a[1]), .tx_out(tx_out_a[1]), .tx_done(tx_done_a[1]));
  uart_tx #(.CLKS_PER_BIT(16), .DATA_BITS(7)) u_dut2 (
    .clk(clk), .n_rst(n_rst), .tx_data(tx_data_a[2][6:0]), .tx_start(tx_start_a[2]),
    .ready(ready_a[2]), .tx_out(tx_out_a[2]), .tx_done(tx_done_a[2]));

  function automatic int flen(input int k);
    return CPB[k] * (DB[k] + 2);
  endfunction

  // Model update: a frame starts when the line is free and start is high.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < NI; k++) begin
        mact[k] <= 1'b0;
        mt[k]   <= 0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (!mact[k] || mt[k] == flen(k)) begin
          if (tx_start_a[k]) begin
            mact[k]  <= 1'b1;
            mt[k]    <= 0;
            mdata[k] <= tx_data_a[k];
          end else begin
            mact[k] <= 1'b0;
          end
        end else begin
          mt[k] <= mt[k] + 1;
        end
      end
    end
  end

  // Expected {tx_out, ready, tx_done} from the position within the frame.
  function automatic logic [2:0] exp_out(input int k);
    int c;
    int d;
    int t;
    c = CPB[k];
    d = DB[k];
    t = mt[k];
    if (!mact[k])          return 3'b110;
    if (t == c * (d + 2))  return 3'b111;
    if (t < c)             return 3'b000;
    if (t < c * (d + 1))   return {mdata[k][t / c - 1], 2'b00};
    return 3'b100;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("dut%0d out/ready/done", k),
            {13'd0, tx_out_a[k], ready_a[k], tx_done_a[k]}, {13'd0, exp_out(k)});
    end
  endtask

  // One clock: step past the edge, then compare every instance to the model.
  task automatic tick();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Observe a frame already accepted (t = 0 now): mid-bit decode, count
  // busy cycles, note when done pulses; optionally poke a start while busy.
  task automatic observe(input int k, input int inject_at, output logic [7:0] dec,
                         output int len, output int done_at);
    int c;
    int d;
    int l;
    c = CPB[k];
    d = DB[k];
    l = flen(k);
    dec = 8'h00;
    len = 0;
    done_at = -1;
    for (int n = 0; n <= l + 2; n++) begin
      if (ready_a[k] === 1'b0) len++;
      if (tx_done_a[k] === 1'b1) done_at = n;
      if (n >= c && n < c * (d + 1) && (n % c) == c / 2) dec[n / c - 1] = tx_out_a[k];
      if (n == inject_at) begin
        tx_start_a[k] = 1'b1;
        tx_data_a[k]  = 8'hFF;
      end else begin
        tx_start_a[k] = 1'b0;
      end
      tick();
    end
  endtask

  task automatic run_frame(input int k, input logic [7:0] data, input int inject_at,
                           output logic [7:0] dec, output int len, output int done_at);
    tx_data_a[k]  = data;
    tx_start_a[k] = 1'b1;
    tick();
    tx_start_a[k] = 1'b0;
    tx_data_a[k]  = ~data;
    observe(k, inject_at, dec, len, done_at);
  endtask

  logic [7:0] dec;
  int         len;
  int         done_at;

  initial begin
    n_rst = 1'b0;
    tx_start_a = '0;
    for (int k = 0; k < NI; k++) tx_data_a[k] = 8'h00;

    // Reset held for three cycles, then a long quiet idle.
    repeat (3) tick();
    check("reset tx_out", {15'd0, tx_out_a[0]}, 16'd1);
    check("reset ready", {15'd0, ready_a[0]}, 16'd1);
    check("reset tx_done", {15'd0, tx_done_a[0]}, 16'd0);
    n_rst = 1'b1;
    repeat (50) tick();
    check("idle lines", {13'd0, tx_out_a}, 16'h0007);

    // Single frame A5: line 0,1,0,1,0,0,1,0,1,1.
    run_frame(0, 8'hA5, -1, dec, len, done_at);
    check("A5 decode", {8'd0, dec}, 16'h00A5);
    check("A5 busy cycles", 16'(len), 16'd100);
    check("A5 done cycle", 16'(done_at), 16'd100);

    // Start with FF while busy at cycle 35 must be ignored.
    run_frame(0, 8'h3C, 35, dec, len, done_at);
    check("busy 3C decode", {8'd0, dec}, 16'h003C);
    check("busy single frame", 16'(len), 16'd100);
    repeat (20) tick();
    check("busy no 2nd frame", {15'd0, ready_a[0]}, 16'd1);

    // Back-to-back 00 then FF with start held high.
    tx_data_a[0]  = 8'h00;
    tx_start_a[0] = 1'b1;
    tick();
    tx_data_a[0] = 8'hFF;
    repeat (100) tick();
    check("b2b done pulse", {14'd0, tx_done_a[0], tx_out_a[0]}, 16'd3);
    tick();
    check("b2b 2nd start", {14'd0, tx_out_a[0], ready_a[0]}, 16'd0);
    tx_start_a[0] = 1'b0;
    observe(0, -1, dec, len, done_at);
    check("b2b FF decode", {8'd0, dec}, 16'h00FF);
    check("b2b FF done cycle", 16'(done_at), 16'd100);

    // Reset at cycle 47 of a frame, then a clean 81 frame.
    tx_data_a[0]  = 8'h55;
    tx_start_a[0] = 1'b1;
    tick();
    tx_start_a[0] = 1'b0;
    repeat (47) tick();
    #2 n_rst = 1'b0;
    #1;
    check("midreset tx_out", {15'd0, tx_out_a[0]}, 16'd1);
    check("midreset ready", {15'd0, ready_a[0]}, 16'd1);
    check("midreset tx_done", {15'd0, tx_done_a[0]}, 16'd0);
    repeat (2) tick();
    n_rst = 1'b1;
    repeat (5) tick();
    run_frame(0, 8'h81, -1, dec, len, done_at);
    check("post-reset 81 decode", {8'd0, dec}, 16'h0081);
    check("post-reset 81 length", 16'(len), 16'd100);

    // Other timings: 2 clocks x 5 bits, 16 clocks x 7 bits.
    run_frame(1, 8'h16, -1, dec, len, done_at);
    check("c2d5 decode", {8'd0, dec}, 16'h0016);
    check("c2d5 length", 16'(len), 16'd14);
    check("c2d5 done cycle", 16'(done_at), 16'd14);
    run_frame(2, 8'h5B, -1, dec, len, done_at);
    check("c16d7 decode", {8'd0, dec}, 16'h005B);
    check("c16d7 length", 16'(len), 16'd144);
    check("c16d7 done cycle", 16'(done_at), 16'd144);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
